// File: rtl/alu_system_ctrl_seq_if.sv
// alu_system_ctrl_seq_if
// Bundle between the hardwired control sequencer and the ALU datapath top.
//   master : sequencer side, consumes IR_Out/ALU_Flags, drives all controls
//   slave  : datapath side, drives IR_Out/ALU_Flags, consumes all controls
// Signals:
//   IR_Out[15:0]      instruction register contents
//   ALU_Flags[3:0]    {O,N,C,Z}, Z = bit 0
//   RF_*  / ARF_*     register file / address register file controls
//   ALU_FunSel        ALU function
//   IR_*              instruction register controls
//   Mem_WR, Mem_CS    memory write strobe, chip select (active-low)
//   Mux*Sel           datapath mux selects
//   Halted, Illegal   sequencer status
//   State             current sequencer state (debug)
interface alu_system_ctrl_seq_if;
    logic [15:0] IR_Out;
    logic [3:0]  ALU_Flags;
    logic [2:0]  RF_O1Sel;
    logic [2:0]  RF_O2Sel;
    logic [1:0]  RF_FunSel;
    logic [3:0]  RF_RSel;
    logic [3:0]  RF_TSel;
    logic [3:0]  ALU_FunSel;
    logic [1:0]  ARF_OutASel;
    logic [1:0]  ARF_OutBSel;
    logic [1:0]  ARF_FunSel;
    logic [3:0]  ARF_RSel;
    logic        IR_LH;
    logic        IR_Enable;
    logic [1:0]  IR_Funsel;
    logic        Mem_WR;
    logic        Mem_CS;
    logic [1:0]  MuxASel;
    logic [1:0]  MuxBSel;
    logic        MuxCSel;
    logic        Halted;
    logic        Illegal;
    logic [2:0]  State;

    modport master (
        input  IR_Out, ALU_Flags,
        output RF_O1Sel, RF_O2Sel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
               ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RSel,
               IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
               MuxASel, MuxBSel, MuxCSel, Halted, Illegal, State
    );

    modport slave (
        output IR_Out, ALU_Flags,
        input  RF_O1Sel, RF_O2Sel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
               ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RSel,
               IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
               MuxASel, MuxBSel, MuxCSel, Halted, Illegal, State
    );
endinterface

// File: rtl/alu_system_ctrl_seq.sv
// alu_system_ctrl_seq
// Hardwired fetch/decode/execute control sequencer for the ALU datapath.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      alu_system_ctrl_seq_if.master (IR/flags in, all controls out)
// Parameter:
//   STEP_CYCLES  cycles each micro-step is held (>= 1)
// Optional build macro:
//   ALU_SYSTEM_CTRL_ILLEGAL_TRAP_EN  opcodes 7-E halt with Illegal=1
//                                    (otherwise they run as a one-step NOP)
//
// state    | meaning
// ---------+------------------------------------------------------
// CLR      | clear all registers once after reset release
// FETCH_L  | IR low byte <- M[PC], PC <- PC+1
// FETCH_H  | IR high byte <- M[PC], PC <- PC+1
// DECODE   | sample opcode, register index and Z flag
// EXEC1    | first execute step
// EXEC2    | second execute step (LDM, ST only)
// HALT     | stopped until reset
module alu_system_ctrl_seq #(
    parameter int STEP_CYCLES = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    alu_system_ctrl_seq_if.master       bus
);

    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [SW-1:0] LAST = SW'(STEP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_CLR     = 3'b000,
        S_FETCH_L = 3'b001,
        S_FETCH_H = 3'b010,
        S_DECODE  = 3'b011,
        S_EXEC1   = 3'b100,
        S_EXEC2   = 3'b101,
        S_HALT    = 3'b110
    } state_t;

    typedef struct packed {
        logic [2:0] rf_o1sel;
        logic [2:0] rf_o2sel;
        logic [1:0] rf_funsel;
        logic [3:0] rf_rsel;
        logic [3:0] rf_tsel;
        logic [3:0] alu_funsel;
        logic [1:0] arf_outasel;
        logic [1:0] arf_outbsel;
        logic [1:0] arf_funsel;
        logic [3:0] arf_rsel;
        logic       ir_lh;
        logic       ir_enable;
        logic [1:0] ir_funsel;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] muxasel;
        logic [1:0] muxbsel;
        logic       muxcsel;
        logic       halted;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t IDLE = ctrl_t'(43'h80);   // everything 0 except Mem_CS=1

    state_t         r_state;
    logic [SW-1:0]  r_step;
    logic [3:0]     r_op;
    logic [1:0]     r_reg;
    logic           r_z;
    ctrl_t          r_ctrl;

    state_t         w_nxt_state;
    logic [SW-1:0]  w_nxt_step;
    logic           w_last;
    logic           w_wr;
    logic [3:0]     w_op;
    logic [1:0]     w_reg;
    logic           w_z;
    logic [3:0]     w_rsel;
    ctrl_t          w_ctrl;
    logic           w_unused;

    assign w_unused = ^{bus.IR_Out[11:10], bus.IR_Out[7:0], bus.ALU_Flags[3:1]};

`ifdef ALU_SYSTEM_CTRL_ILLEGAL_TRAP_EN
    logic w_is_ill;
    assign w_is_ill = (w_op >= 4'h7) && (w_op <= 4'hE);
`endif

    // Outputs are registered, so everything below is evaluated for the
    // state/step that will be current after the next edge. Leaving DECODE,
    // the opcode is taken straight from IR since it is latched on that edge.
    always_comb begin
        w_last     = (r_step == LAST);
        w_nxt_step = w_last ? '0 : r_step + 1'b1;
        w_op       = (r_state == S_DECODE) ? bus.IR_Out[15:12] : r_op;
        w_reg      = (r_state == S_DECODE) ? bus.IR_Out[9:8]   : r_reg;
        w_z        = (r_state == S_DECODE) ? bus.ALU_Flags[0]  : r_z;
        w_rsel     = 4'b1000 >> w_reg;

        w_nxt_state = r_state;
        if (w_last) begin
            case (r_state)
                S_CLR:     w_nxt_state = S_FETCH_L;
                S_FETCH_L: w_nxt_state = S_FETCH_H;
                S_FETCH_H: w_nxt_state = S_DECODE;
                S_DECODE:  w_nxt_state = S_EXEC1;
                S_EXEC1: begin
                    if (w_op == 4'h1 || w_op == 4'h2)
                        w_nxt_state = S_EXEC2;
                    else if (w_op == 4'hF)
                        w_nxt_state = S_HALT;
`ifdef ALU_SYSTEM_CTRL_ILLEGAL_TRAP_EN
                    else if (w_is_ill)
                        w_nxt_state = S_HALT;
`endif
                    else
                        w_nxt_state = S_FETCH_L;
                end
                S_EXEC2:   w_nxt_state = S_FETCH_L;
                default:   w_nxt_state = S_HALT;
            endcase
        end

        // Write-class fields only on the final cycle of a step.
        w_wr   = (w_nxt_step == LAST);
        w_ctrl = IDLE;
        case (w_nxt_state)
            S_CLR: begin
                if (w_wr) begin
                    w_ctrl.arf_rsel  = 4'b1111;
                    w_ctrl.rf_rsel   = 4'b1111;
                    w_ctrl.rf_tsel   = 4'b1111;
                    w_ctrl.ir_enable = 1'b1;
                end
            end
            S_FETCH_L, S_FETCH_H: begin
                w_ctrl.arf_outbsel = 2'b11;
                w_ctrl.mem_cs      = 1'b0;
                w_ctrl.ir_funsel   = 2'b01;
                w_ctrl.ir_lh       = (w_nxt_state == S_FETCH_H);
                w_ctrl.arf_funsel  = 2'b10;
                if (w_wr) begin
                    w_ctrl.ir_enable = 1'b1;
                    w_ctrl.arf_rsel  = 4'b1000;
                end
            end
            S_EXEC1: begin
                case (w_op)
                    4'h0: begin
                        w_ctrl.muxasel   = 2'b10;
                        w_ctrl.rf_funsel = 2'b01;
                        if (w_wr) w_ctrl.rf_rsel = w_rsel;
                    end
                    4'h1, 4'h2: begin
                        w_ctrl.muxbsel    = 2'b10;
                        w_ctrl.arf_funsel = 2'b01;
                        if (w_wr) w_ctrl.arf_rsel = 4'b0100;
                    end
                    4'h3, 4'h4: begin
                        w_ctrl.rf_funsel = (w_op == 4'h3) ? 2'b11 : 2'b10;
                        if (w_wr) w_ctrl.rf_rsel = w_rsel;
                    end
                    4'h5, 4'h6: begin
                        if (w_op == 4'h5 || w_z) begin
                            w_ctrl.muxbsel    = 2'b10;
                            w_ctrl.arf_funsel = 2'b01;
                            if (w_wr) w_ctrl.arf_rsel = 4'b1000;
                        end
                    end
                    default: ;
                endcase
            end
            S_EXEC2: begin
                w_ctrl.arf_outbsel = 2'b00;
                w_ctrl.mem_cs      = 1'b0;
                if (w_op == 4'h1) begin
                    w_ctrl.muxasel   = 2'b01;
                    w_ctrl.rf_funsel = 2'b01;
                    if (w_wr) w_ctrl.rf_rsel = w_rsel;
                end else begin
                    w_ctrl.rf_o1sel   = {1'b1, w_reg};
                    w_ctrl.muxcsel    = 1'b0;
                    w_ctrl.alu_funsel = 4'b0000;
                    if (w_wr) w_ctrl.mem_wr = 1'b1;
                end
            end
            S_HALT: begin
                w_ctrl.halted = 1'b1;
`ifdef ALU_SYSTEM_CTRL_ILLEGAL_TRAP_EN
                w_ctrl.illegal = w_is_ill;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_CLR;
            r_step  <= '0;
            r_op    <= '0;
            r_reg   <= '0;
            r_z     <= 1'b0;
            r_ctrl  <= IDLE;
        end else begin
            r_state <= w_nxt_state;
            r_step  <= w_nxt_step;
            r_op    <= w_op;
            r_reg   <= w_reg;
            r_z     <= w_z;
            r_ctrl  <= w_ctrl;
        end
    end

    assign bus.RF_O1Sel    = r_ctrl.rf_o1sel;
    assign bus.RF_O2Sel    = r_ctrl.rf_o2sel;
    assign bus.RF_FunSel   = r_ctrl.rf_funsel;
    assign bus.RF_RSel     = r_ctrl.rf_rsel;
    assign bus.RF_TSel     = r_ctrl.rf_tsel;
    assign bus.ALU_FunSel  = r_ctrl.alu_funsel;
    assign bus.ARF_OutASel = r_ctrl.arf_outasel;
    assign bus.ARF_OutBSel = r_ctrl.arf_outbsel;
    assign bus.ARF_FunSel  = r_ctrl.arf_funsel;
    assign bus.ARF_RSel    = r_ctrl.arf_rsel;
    assign bus.IR_LH       = r_ctrl.ir_lh;
    assign bus.IR_Enable   = r_ctrl.ir_enable;
    assign bus.IR_Funsel   = r_ctrl.ir_funsel;
    assign bus.Mem_WR      = r_ctrl.mem_wr;
    assign bus.Mem_CS      = r_ctrl.mem_cs;
    assign bus.MuxASel     = r_ctrl.muxasel;
    assign bus.MuxBSel     = r_ctrl.muxbsel;
    assign bus.MuxCSel     = r_ctrl.muxcsel;
    assign bus.Halted      = r_ctrl.halted;
    assign bus.Illegal     = r_ctrl.illegal;
    assign bus.State       = r_state;

endmodule

// File: doc/alu_system_ctrl_seq.md
Name: alu_system_ctrl_seq

Overview:
- Hardwired control sequencer that drives every control input of the ALU datapath top (register files, ALU, address registers, IR, memory, muxes).
- Sits directly upstream of the datapath.
- Consumes the datapath's IR contents and ALU flags, which are brought out of the datapath top as extra ports.
- Runs a fetch (two bytes into IR), decode and execute loop over a small fixed instruction set.

Parameters:
STEP_CYCLES, 2, clock cycles each micro-step is held; minimum 1; covers the registered mux/ALU/output stages of the datapath.

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  asynchronous active-low reset
IR_Out  in  16  instruction register contents
ALU_Flags  in  4  {O,N,C,Z}; Z = bit 0
RF_O1Sel, RF_O2Sel  out  3 each  register file output selects
RF_FunSel  out  2  register file function
RF_RSel, RF_TSel  out  4 each  one-hot R / T write selects
ALU_FunSel  out  4  ALU function
ARF_OutASel, ARF_OutBSel  out  2 each  address register file output selects
ARF_FunSel  out  2  address register file function
ARF_RSel  out  4  {PC,AR,SP,PCPast} write select
IR_LH, IR_Enable  out  1 each  IR byte select / enable
IR_Funsel  out  2  IR function
Mem_WR  out  1  memory write (1 = write)
Mem_CS  out  1  memory chip select, active-low
MuxASel, MuxBSel  out  2 each  datapath mux selects
MuxCSel  out  1  datapath mux select
Halted  out  1  sequencer stopped
Illegal  out  1  undefined opcode trapped
State  out  3  current state, debug

Behaviour:
- Idle bundle (reset value of all control outputs, and in every state and cycle not listed below):
  - all RSel/TSel = 0000, IR_Enable=0, Mem_CS=1, Mem_WR=0.
  - all other selects/FunSels = 0.
  - Halted=0, Illegal=0, State=CLR(000).
- Reset low: all outputs go to the idle bundle immediately (asynchronous), step counter=0, State=CLR. Mid-instruction state is abandoned.
- Step counter counts 0..STEP_CYCLES-1 within each state.
  - Select fields are driven for the whole step.
  - Write-class fields are asserted only on the final cycle: RF_RSel/TSel, ARF_RSel, IR_Enable, Mem_WR.
  - State advances on the final cycle.
- Instruction word:
  - IR[15:12] = opcode.
  - IR[9:8] = register index: 00=R1, 01=R2, 10=R3, 11=R4. Maps to RF_RSel 1000/0100/0010/0001 and O1Sel 100/101/110/111.
  - IR[7:0] = immediate/address.
- States:
  - CLR(000): ARF_FunSel=00, ARF_RSel=1111, RF_FunSel=00, RF_RSel=1111, RF_TSel=1111, IR_Funsel=00, IR_Enable -> FETCH_L.
  - FETCH_L(001): ARF_OutBSel=11, Mem_CS=0, IR_Funsel=01, IR_LH=0, IR_Enable, ARF_FunSel=10, ARF_RSel=1000 (PC+1) -> FETCH_H.
  - FETCH_H(010): same as FETCH_L with IR_LH=1 -> DECODE.
  - DECODE(011): no writes. Samples opcode and ALU_Flags[0] -> EXEC1.
  - EXEC1(100), then EXEC2(101) where listed, per opcode:
    - 0 LDI: MuxASel=10, RF_FunSel=01, RSel=reg.
    - 1 LDM: EXEC1 AR<-imm (MuxBSel=10, ARF_FunSel=01, ARF_RSel=0100); EXEC2 ARF_OutBSel=00, Mem_CS=0, MuxASel=01, RF_FunSel=01, RSel=reg.
    - 2 ST: EXEC1 as LDM; EXEC2 RF_O1Sel=reg, MuxCSel=0, ALU_FunSel=0000, ARF_OutBSel=00, Mem_CS=0, Mem_WR.
    - 3 INC: RF_FunSel=11, RSel=reg.
    - 4 DEC: RF_FunSel=10, RSel=reg.
    - 5 BRA: MuxBSel=10, ARF_FunSel=01, ARF_RSel=1000.
    - 6 BEQ: as BRA if the sampled Z=1, else the idle bundle.
    - F HLT -> HALT.
    - Other opcodes: see Optional Feature.
  - After the last EXEC step -> FETCH_L.
  - HALT(110): idle bundle, Halted=1. Held until Reset.
- Timing:
  - An instruction takes (3 + number of EXEC steps) x STEP_CYCLES cycles.
  - CLR runs once after each reset release.
  - PC wraps 0xFF -> 0x00 inside the datapath; the sequencer ignores wrap.

Optional Feature:
- ALU_SYSTEM_CTRL_ILLEGAL_TRAP_EN
  - Defined: opcodes 7-E go to HALT with Illegal=1 and Halted=1.
  - Undefined: opcodes 7-E execute as a one-step NOP (idle bundle) and Illegal stays 0.

Test Plan:
- STEP_CYCLES=2, Reset pulsed low during FETCH_H cycle 1 -> outputs equal the idle bundle in the same cycle, State=000. After release, CLR spans 2 cycles with ARF_RSel=1111 only in the 2nd cycle.
- IR_Out=16'h012A (LDI R2,0x2A) -> EXEC1 has MuxASel=10, RF_FunSel=01, RF_RSel=0100 on its final cycle. 8 cycles from FETCH_L entry back to FETCH_L.
- IR_Out=16'h2380 (ST R4,[0x80]) -> EXEC1 ARF_RSel=0100, MuxBSel=10. EXEC2 RF_O1Sel=111, ARF_OutBSel=00, Mem_CS=0 for both cycles, Mem_WR=1 on the 2nd cycle only.
- IR_Out=16'h6040, ALU_Flags=0000 -> EXEC1 idle. Repeated with ALU_Flags=0001 -> ARF_FunSel=01, ARF_RSel=1000, MuxBSel=10.
- IR_Out=16'hF000 -> State=110, Halted=1, idle bundle for 50 cycles, no IR_Enable.
- IR_Out=16'h7000 -> with macro: HALT, Illegal=1; without macro: single idle EXEC1, then FETCH_L, Illegal=0.
